// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction-fetch stage. Holds the PC, issues word-aligned
//                requests to instruction memory (one outstanding at most),
//                buffers responses in a 2-entry FIFO and hands them to decode
//                through a valid/ready handshake. A redirect flushes the
//                FIFO, kills any in-flight response and restarts at a new PC.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_instruction,
    output logic [31:0] if_pc,
    input  logic        id_ready
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_req_pc;
    logic [1:0]  r_count;
    // Entry 0 is always the head; entry 1 is the tail when two are held.
    logic [31:0] r_pc0;
    logic [31:0] r_instr0;
    logic [31:0] r_pc1;
    logic [31:0] r_instr1;

    logic        w_req_fire;
    logic        w_push;
    logic        w_pop;
    logic [31:0] w_redirect_pc;

    // Low address bits are dropped so fetch always stays word aligned.
    assign w_redirect_pc  = redirect_pc & 32'hFFFF_FFFC;

    // Gating with rst_n keeps the request low for the whole reset window.
    assign imem_req_valid = rst_n && (r_state == S_REQ) && (r_count < 2'd2)
                            && !redirect_valid;
    assign w_req_fire     = imem_req_valid && imem_req_ready;
    assign imem_addr      = r_pc;

    assign if_valid       = (r_count != 2'd0);
    assign if_pc          = r_pc0;
    assign if_instruction = r_instr0;
    assign w_pop          = if_valid && id_ready && !redirect_valid;

    // Fetch state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_REQ;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and push decision; a redirect overrides the normal flow.
    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        case (r_state)
            S_REQ: begin
                if (w_req_fire) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    w_push      = 1'b1;
                    w_state_nxt = S_REQ;
                end
            end
            S_DROP: begin
                if (imem_rsp_valid) begin
                    w_state_nxt = S_REQ;
                end
            end
            default: begin
                w_state_nxt = S_REQ;
            end
        endcase
        if (redirect_valid) begin
            w_push = 1'b0;
            case (r_state)
                S_WAIT:  w_state_nxt = imem_rsp_valid ? S_REQ : S_DROP;
                S_DROP:  w_state_nxt = imem_rsp_valid ? S_REQ : S_DROP;
                default: w_state_nxt = S_REQ;
            endcase
        end
    end

    // Program counter and the PC tag of the outstanding request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc     <= RESET_PC;
            r_req_pc <= 32'h0;
        end else if (redirect_valid) begin
            r_pc <= w_redirect_pc;
        end else if (w_req_fire) begin
            r_req_pc <= r_pc;
            r_pc     <= r_pc + 32'd4;
        end
    end

    // Two-entry shift FIFO; entries are left untouched when emptied so the
    // head outputs keep showing the last instruction presented.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count  <= 2'd0;
            r_pc0    <= 32'h0;
            r_instr0 <= 32'h0;
            r_pc1    <= 32'h0;
            r_instr1 <= 32'h0;
        end else if (redirect_valid) begin
            r_count <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_pc0    <= r_req_pc;
                        r_instr0 <= imem_rsp_data;
                    end else begin
                        r_pc1    <= r_req_pc;
                        r_instr1 <= imem_rsp_data;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    if (r_count == 2'd2) begin
                        r_pc0    <= r_pc1;
                        r_instr0 <= r_instr1;
                    end
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_pc0    <= r_req_pc;
                        r_instr0 <= imem_rsp_data;
                    end else begin
                        r_pc0    <= r_pc1;
                        r_instr0 <= r_instr1;
                        r_pc1    <= r_req_pc;
                        r_instr1 <= imem_rsp_data;
                    end
                end
                default: begin
                    r_count <= r_count;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Directed self-checking bench for fetch_unit with a
//                latency-configurable instruction memory model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_instruction;
    logic [31:0] if_pc;
    logic        id_ready;

    int errors;
    int checks;
    int mem_lat;

    logic        r_pend;
    int          r_cnt;
    logic [31:0] r_paddr;

    fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_instruction (if_instruction),
        .if_pc          (if_pc),
        .id_ready       (id_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: returns addr ^ A5A5_0000 mem_lat cycles after acceptance.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend         <= 1'b0;
            r_cnt          <= 0;
            r_paddr        <= 32'h0;
            imem_rsp_valid <= 1'b0;
            imem_rsp_data  <= 32'h0;
        end else begin
            imem_rsp_valid <= 1'b0;
            if (imem_req_valid && imem_req_ready) begin
                if (mem_lat == 1) begin
                    imem_rsp_valid <= 1'b1;
                    imem_rsp_data  <= imem_addr ^ 32'hA5A5_0000;
                end else begin
                    r_pend  <= 1'b1;
                    r_cnt   <= mem_lat - 2;
                    r_paddr <= imem_addr;
                end
            end else if (r_pend) begin
                if (r_cnt == 0) begin
                    imem_rsp_valid <= 1'b1;
                    imem_rsp_data  <= r_paddr ^ 32'hA5A5_0000;
                    r_pend         <= 1'b0;
                end else begin
                    r_cnt <= r_cnt - 1;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Leaves the bench in cycle 0 after reset release, outputs settled.
    task automatic do_reset(input int lat, input logic rdy);
        rst_n          = 1'b0;
        mem_lat        = lat;
        id_ready       = rdy;
        imem_req_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n          = 1'b0;
        mem_lat        = 1;
        id_ready       = 1'b1;
        imem_req_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        @(posedge clk);
        #2;
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rst_if_valid got=%b exp=0", if_valid); end
        checks++; if (if_instruction !== 32'h0) begin errors++; $display("FAIL rst_if_instruction got=%h exp=0", if_instruction); end
        checks++; if (if_pc !== 32'h0) begin errors++; $display("FAIL rst_if_pc got=%h exp=0", if_pc); end
        checks++; if (imem_addr !== 32'h100) begin errors++; $display("FAIL rst_imem_addr got=%h exp=00000100", imem_addr); end
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid got=%b exp=0", imem_req_valid); end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_addr [3];
        logic [31:0] exp_data [3];
        int nreq, npop, first_req, first_valid;
        exp_addr = '{32'h100, 32'h104, 32'h108};
        exp_data = '{32'hA5A5_0100, 32'hA5A5_0104, 32'hA5A5_0108};
        nreq = 0; npop = 0; first_req = -1; first_valid = -1;
        do_reset(1, 1'b1);
        for (int c = 0; c < 12; c++) begin
            if (imem_req_valid && imem_req_ready) begin
                if (first_req < 0) first_req = c;
                if (nreq < 3) begin
                    checks++; if (imem_addr !== exp_addr[nreq]) begin errors++; $display("FAIL seq_addr[%0d] got=%h exp=%h", nreq, imem_addr, exp_addr[nreq]); end
                end
                nreq++;
            end
            if (if_valid) begin
                if (first_valid < 0) first_valid = c;
                if (npop < 3) begin
                    checks++; if (if_pc !== exp_addr[npop]) begin errors++; $display("FAIL seq_if_pc[%0d] got=%h exp=%h", npop, if_pc, exp_addr[npop]); end
                    checks++; if (if_instruction !== exp_data[npop]) begin errors++; $display("FAIL seq_if_instr[%0d] got=%h exp=%h", npop, if_instruction, exp_data[npop]); end
                end
                npop++;
            end
            step();
        end
        checks++; if (first_req !== 0) begin errors++; $display("FAIL seq_first_req_cycle got=%0d exp=0", first_req); end
        checks++; if (first_valid !== 2) begin errors++; $display("FAIL seq_first_valid_cycle got=%0d exp=2", first_valid); end
        checks++; if (npop < 3) begin errors++; $display("FAIL seq_pop_count got=%0d exp>=3", npop); end
    endtask

    task automatic test_backpressure();
        logic [31:0] pops [3];
        int nreq, npop, first_req;
        logic [31:0] first_addr;
        nreq = 0; npop = 0; first_req = -1; first_addr = 32'h0;
        do_reset(1, 1'b0);
        for (int c = 0; c < 10; c++) begin
            if (imem_req_valid && imem_req_ready) nreq++;
            step();
        end
        checks++; if (nreq !== 2) begin errors++; $display("FAIL bp_req_count got=%0d exp=2", nreq); end
        checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL bp_if_valid got=%b exp=1", if_valid); end
        checks++; if (if_pc !== 32'h100) begin errors++; $display("FAIL bp_if_pc_held got=%h exp=00000100", if_pc); end
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL bp_req_valid got=%b exp=0", imem_req_valid); end
        id_ready = 1'b1;
        #1;
        for (int c = 0; c < 8; c++) begin
            if (imem_req_valid && imem_req_ready && first_req < 0) begin
                first_req  = c;
                first_addr = imem_addr;
            end
            if (if_valid && npop < 3) begin
                pops[npop] = if_pc;
                npop++;
            end
            step();
        end
        checks++; if (npop !== 3) begin errors++; $display("FAIL bp_drain_count got=%0d exp=3", npop); end
        if (npop == 3) begin
            checks++; if (pops[0] !== 32'h100) begin errors++; $display("FAIL bp_drain0 got=%h exp=00000100", pops[0]); end
            checks++; if (pops[1] !== 32'h104) begin errors++; $display("FAIL bp_drain1 got=%h exp=00000104", pops[1]); end
            checks++; if (pops[2] !== 32'h108) begin errors++; $display("FAIL bp_drain2 got=%h exp=00000108", pops[2]); end
        end
        checks++; if (first_req !== 1) begin errors++; $display("FAIL bp_resume_cycle got=%0d exp=1", first_req); end
        checks++; if (first_addr !== 32'h108) begin errors++; $display("FAIL bp_resume_addr got=%h exp=00000108", first_addr); end
    endtask

    task automatic test_redirect_wait();
        int stale_c, first_req, first_valid;
        logic [31:0] first_addr, first_pc, first_instr;
        stale_c = -1; first_req = -1; first_valid = -1;
        first_addr = 32'h0; first_pc = 32'h0; first_instr = 32'h0;
        do_reset(3, 1'b1);
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        #1;
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rw_req_in_redirect got=%b exp=0", imem_req_valid); end
        step();
        redirect_valid = 1'b0;
        #1;
        for (int c = 0; c < 10; c++) begin
            if (imem_rsp_valid && stale_c < 0) stale_c = c;
            if (imem_req_valid && imem_req_ready && first_req < 0) begin
                first_req  = c;
                first_addr = imem_addr;
            end
            if (if_valid && first_valid < 0) begin
                first_valid = c;
                first_pc    = if_pc;
                first_instr = if_instruction;
            end
            step();
        end
        checks++; if (stale_c !== 1) begin errors++; $display("FAIL rw_stale_rsp_cycle got=%0d exp=1", stale_c); end
        checks++; if (first_req !== 2) begin errors++; $display("FAIL rw_first_req_cycle got=%0d exp=2", first_req); end
        checks++; if (first_addr !== 32'h200) begin errors++; $display("FAIL rw_first_addr got=%h exp=00000200", first_addr); end
        checks++; if (first_valid !== 6) begin errors++; $display("FAIL rw_first_valid_cycle got=%0d exp=6", first_valid); end
        checks++; if (first_pc !== 32'h200) begin errors++; $display("FAIL rw_first_if_pc got=%h exp=00000200", first_pc); end
        checks++; if (first_instr !== 32'hA5A5_0200) begin errors++; $display("FAIL rw_first_instr got=%h exp=a5a50200", first_instr); end
    endtask

    task automatic test_redirect_coincident();
        logic [31:0] first_pc;
        int seen;
        first_pc = 32'h0; seen = 0;
        do_reset(1, 1'b0);
        step();
        step();
        step();
        checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL rc_pre_if_valid got=%b exp=1", if_valid); end
        checks++; if (imem_rsp_valid !== 1'b1) begin errors++; $display("FAIL rc_pre_rsp_valid got=%b exp=1", imem_rsp_valid); end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        id_ready       = 1'b1;
        #1;
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rc_req_in_redirect got=%b exp=0", imem_req_valid); end
        step();
        redirect_valid = 1'b0;
        #1;
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rc_if_valid_after got=%b exp=0", if_valid); end
        checks++; if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL rc_req_valid_after got=%b exp=1", imem_req_valid); end
        checks++; if (imem_addr !== 32'h200) begin errors++; $display("FAIL rc_addr_after got=%h exp=00000200", imem_addr); end
        for (int c = 0; c < 6; c++) begin
            if (if_valid && seen == 0) begin
                first_pc = if_pc;
                seen     = 1;
            end
            step();
        end
        checks++; if (first_pc !== 32'h200) begin errors++; $display("FAIL rc_first_if_pc got=%h exp=00000200", first_pc); end
    endtask

    task automatic test_align_wrap();
        logic [31:0] reqs [2];
        logic [31:0] pcs [2];
        logic [31:0] ins [2];
        int nreq, npop;
        nreq = 0; npop = 0;
        do_reset(1, 1'b1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h203;
        #1;
        step();
        redirect_valid = 1'b0;
        #1;
        checks++; if (imem_addr !== 32'h200) begin errors++; $display("FAIL aw_aligned_addr got=%h exp=00000200", imem_addr); end
        checks++; if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL aw_aligned_req got=%b exp=1", imem_req_valid); end
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        #1;
        step();
        redirect_valid = 1'b0;
        #1;
        for (int c = 0; c < 8; c++) begin
            if (imem_req_valid && imem_req_ready && nreq < 2) begin
                reqs[nreq] = imem_addr;
                nreq++;
            end
            if (if_valid && npop < 2) begin
                pcs[npop] = if_pc;
                ins[npop] = if_instruction;
                npop++;
            end
            step();
        end
        checks++; if (nreq !== 2 || npop !== 2) begin errors++; $display("FAIL aw_counts got=%0d/%0d exp=2/2", nreq, npop); end
        if (nreq == 2 && npop == 2) begin
            checks++; if (reqs[0] !== 32'hFFFF_FFFC) begin errors++; $display("FAIL aw_req0 got=%h exp=fffffffc", reqs[0]); end
            checks++; if (reqs[1] !== 32'h0) begin errors++; $display("FAIL aw_req1_wrap got=%h exp=00000000", reqs[1]); end
            checks++; if (pcs[0] !== 32'hFFFF_FFFC) begin errors++; $display("FAIL aw_pc0 got=%h exp=fffffffc", pcs[0]); end
            checks++; if (ins[0] !== 32'h5A5A_FFFC) begin errors++; $display("FAIL aw_ins0 got=%h exp=5a5afffc", ins[0]); end
            checks++; if (pcs[1] !== 32'h0) begin errors++; $display("FAIL aw_pc1 got=%h exp=00000000", pcs[1]); end
            checks++; if (ins[1] !== 32'hA5A5_0000) begin errors++; $display("FAIL aw_ins1 got=%h exp=a5a50000", ins[1]); end
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] first_pc;
        int seen;
        first_pc = 32'h0; seen = 0;
        do_reset(3, 1'b0);
        for (int c = 0; c < 5; c++) step();
        checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL ar_pre_if_valid got=%b exp=1", if_valid); end
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL ar_pre_req_valid got=%b exp=0", imem_req_valid); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL ar_if_valid got=%b exp=0", if_valid); end
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL ar_req_valid got=%b exp=0", imem_req_valid); end
        checks++; if (if_pc !== 32'h0) begin errors++; $display("FAIL ar_if_pc got=%h exp=0", if_pc); end
        checks++; if (imem_addr !== 32'h100) begin errors++; $display("FAIL ar_imem_addr got=%h exp=00000100", imem_addr); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        id_ready = 1'b1;
        #1;
        checks++; if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL ar_restart_req got=%b exp=1", imem_req_valid); end
        checks++; if (imem_addr !== 32'h100) begin errors++; $display("FAIL ar_restart_addr got=%h exp=00000100", imem_addr); end
        for (int c = 0; c < 8; c++) begin
            if (if_valid && seen == 0) begin
                first_pc = if_pc;
                seen     = 1;
            end
            step();
        end
        checks++; if (first_pc !== 32'h100) begin errors++; $display("FAIL ar_first_if_pc got=%h exp=00000100", first_pc); end
    endtask

    initial begin
        errors         = 0;
        checks         = 0;
        mem_lat        = 1;
        rst_n          = 1'b0;
        imem_req_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        id_ready       = 1'b1;
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect_wait();
        test_redirect_coincident();
        test_align_wrap();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
